// File: rtl/nand_logic_defs.sv
// Shared encodings for the NAND logic sequencer: opcodes, FSM states, pass counts
// and the per-pass schedule that routes operands through the single NAND array.
package nand_logic_defs;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] PASSES_NOT = 3'd1;
  localparam logic [2:0] PASSES_AND = 3'd2;
  localparam logic [2:0] PASSES_OR  = 3'd3;
  localparam logic [2:0] PASSES_XOR = 3'd4;

  typedef enum logic [2:0] {
    SEL_A  = 3'd0,
    SEL_B  = 3'd1,
    SEL_S0 = 3'd2,
    SEL_S1 = 3'd3,
    SEL_S2 = 3'd4
  } sel_e;

  typedef enum logic [1:0] {
    DST_S0  = 2'd0,
    DST_S1  = 2'd1,
    DST_S2  = 2'd2,
    DST_RES = 2'd3
  } dst_e;

  typedef struct packed {
    sel_e x;
    sel_e y;
    dst_e dst;
  } pass_t;

  function automatic logic [2:0] pass_count(input logic [1:0] op);
    logic [2:0] n;
    case (op)
      OP_NOT:  n = PASSES_NOT;
      OP_AND:  n = PASSES_AND;
      OP_OR:   n = PASSES_OR;
      default: n = PASSES_XOR;
    endcase
    return n;
  endfunction

  // Which operands feed the array on pass p, and where its output lands.
  function automatic pass_t pass_plan(input logic [1:0] op, input logic [1:0] p);
    pass_t pl;
    pl = '{SEL_A, SEL_A, DST_RES};
    case (op)
      OP_AND: begin
        if (p == 2'd0) pl = '{SEL_A, SEL_B, DST_S0};
        else           pl = '{SEL_S0, SEL_S0, DST_RES};
      end
      OP_OR: begin
        case (p)
          2'd0:    pl = '{SEL_A, SEL_A, DST_S0};
          2'd1:    pl = '{SEL_B, SEL_B, DST_S1};
          default: pl = '{SEL_S0, SEL_S1, DST_RES};
        endcase
      end
      OP_XOR: begin
        case (p)
          2'd0:    pl = '{SEL_A, SEL_B, DST_S0};
          2'd1:    pl = '{SEL_A, SEL_S0, DST_S1};
          2'd2:    pl = '{SEL_B, SEL_S0, DST_S2};
          default: pl = '{SEL_S1, SEL_S2, DST_RES};
        endcase
      end
      default: pl = '{SEL_A, SEL_A, DST_RES};
    endcase
    return pl;
  endfunction

endpackage

// File: rtl/nand_array.sv
// WIDTH independent two-input NAND gates; the only gate logic in the sequencer datapath.
module nand_array #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output wire  [WIDTH-1:0] z
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nand (z[i], x[i], y[i]);
  end

endmodule

// File: rtl/nand_logic_sequencer.sv
// Multi-cycle NOT/AND/OR/XOR unit that time-shares one NAND array over 1-4 passes,
// keeping intermediates in scratch registers, with valid/ready on both sides.
module nand_logic_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [15:0]      op_count
);

  import nand_logic_defs::*;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [15:0]      op_count_q, op_count_d;

  pass_t            plan;
  logic             last_pass;
  logic [WIDTH-1:0] x_op, y_op;
  wire  [WIDTH-1:0] z;

  // Operand routing depends only on captured op and pass index, never on live inputs.
  assign plan      = pass_plan(op_q, p_q);
  assign last_pass = (({1'b0, p_q} + 3'd1) == pass_count(op_q));

  function automatic logic [WIDTH-1:0] pick(input sel_e sel,
                                            input logic [WIDTH-1:0] va,
                                            input logic [WIDTH-1:0] vb,
                                            input logic [WIDTH-1:0] v0,
                                            input logic [WIDTH-1:0] v1,
                                            input logic [WIDTH-1:0] v2);
    logic [WIDTH-1:0] v;
    case (sel)
      SEL_A:   v = va;
      SEL_B:   v = vb;
      SEL_S0:  v = v0;
      SEL_S1:  v = v1;
      SEL_S2:  v = v2;
      default: v = va;
    endcase
    return v;
  endfunction

  assign x_op = pick(plan.x, a_q, b_q, s0_q, s1_q, s2_q);
  assign y_op = pick(plan.y, a_q, b_q, s0_q, s1_q, s2_q);

  nand_array #(.WIDTH(WIDTH)) u_nand_array (
    .x(x_op),
    .y(y_op),
    .z(z)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    p_d        = p_q;
    a_d        = a_q;
    b_d        = b_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    res_d      = res_q;
    op_count_d = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          p_d     = 2'd0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (plan.dst)
          DST_S0:  s0_d  = z;
          DST_S1:  s1_d  = z;
          DST_S2:  s2_d  = z;
          default: res_d = z;
        endcase
        p_d = p_q + 2'd1;
        if (last_pass) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: scratch and result are reset too, so an aborted op leaves no stale data visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOT;
      p_q        <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      res_q      <= '0;
      op_count_q <= 16'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      op_q       <= op_d;
      p_q        <= p_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      res_q      <= res_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign out_valid = (state_q == ST_RESP);
  assign result    = res_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_nand_logic_sequencer.sv
// Directed bench for nand_logic_sequencer: per-op results and latency, back-to-back
// throughput, backpressure, operand isolation, mid-op reset and op_count wrap.
module tb_nand_logic_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [15:0]      op_count;

  int total = 0;
  int bad   = 0;

  nand_logic_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request, wait for IDLE, then step past the accepting edge.
  task automatic send(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
    op = o; a = va; b = vb; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  initial begin
    int lat;
    int gap;

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", {16'd0, result}, 32'h0);
    check("rst_op_count", {16'd0, op_count}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // NOT: b must be ignored
    out_ready = 1'b1;
    send(2'b00, 16'h00FF, 16'h1234);
    wait_out(lat);
    check("not_lat", lat, 32'd1);
    check("not_res", {16'd0, result}, 32'hFF00);
    @(posedge clk); #1;
    check("not_hs_valid", {31'd0, out_valid}, 32'd0);
    check("not_count", {16'd0, op_count}, 32'd1);
    check("not_idle_ready", {31'd0, in_ready}, 32'd1);

    // AND then OR back-to-back with in_valid held high
    op = 2'b01; a = 16'hF0F0; b = 16'hFF00; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 2'b10;
    wait_out(lat);
    check("and_lat", lat, 32'd2);
    check("and_res", {16'd0, result}, 32'hF000);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while ((!busy || out_valid) && gap < 10);
    check("b2b_gap", gap, 32'd2);
    in_valid = 1'b0;
    wait_out(lat);
    check("or_lat", lat, 32'd3);
    check("or_res", {16'd0, result}, 32'hFFF0);
    @(posedge clk); #1;
    check("or_count", {16'd0, op_count}, 32'd3);

    // XOR with backpressure and a competing request held high
    out_ready = 1'b0;
    send(2'b11, 16'hAAAA, 16'hFFFF);
    op = 2'b00; a = 16'h0F0F; in_valid = 1'b1;
    wait_out(lat);
    check("xor_lat", lat, 32'd4);
    check("xor_res", {16'd0, result}, 32'h5555);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res", {16'd0, result}, 32'h5555);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_count", {16'd0, op_count}, 32'd3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    check("bp_hs_count", {16'd0, op_count}, 32'd4);
    @(posedge clk); #1;
    check("bp_no_extra", {31'd0, busy}, 32'd0);

    // Operands change every cycle during EXEC
    send(2'b11, 16'h1234, 16'h00FF);
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("iso_lat", lat, 32'd4);
    check("iso_res", {16'd0, result}, 32'h12CB);
    @(posedge clk); #1;
    check("iso_count", {16'd0, op_count}, 32'd5);

    // Reset while XOR is at pass 2
    send(2'b11, 16'hAAAA, 16'h5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_count", {16'd0, op_count}, 32'd0);
    check("mrst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b00, 16'h0F0F, 16'h0000);
    wait_out(lat);
    check("post_rst_lat", lat, 32'd1);
    check("post_rst_res", {16'd0, result}, 32'hF0F0);
    @(posedge clk); #1;
    check("post_rst_count", {16'd0, op_count}, 32'd1);

    // op_count wrap
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.op_count_q;
    @(posedge clk); #1;
    check("wrap_pre", {16'd0, op_count}, 32'hFFFF);
    send(2'b00, 16'h1234, 16'h0000);
    wait_out(lat);
    check("wrap_res", {16'd0, result}, 32'hEDCB);
    @(posedge clk); #1;
    check("wrap_count", {16'd0, op_count}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
